// File: rtl/ovrd_auto_gain.sv
`default_nettype none
// ==== ovrd_auto_gain : envelope-driven AGC producing overdrive's gain word, rev 1.0 ====
// Optional macro AGC_FAST_ATTACK_EN: overshoot halves the gain instead of stepping down 1 LSB.
module ovrd_auto_gain #(
   parameter int FXP_SIZE           = 16,
   parameter int BITS_PER_GAIN_FRAC = 4,
   parameter int HOLD_SAMPLES       = 256,
   parameter int RELEASE_DIV        = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   input  logic [2*FXP_SIZE-1:0]   i_sample,
   input  logic                    i_enable,
   input  logic [FXP_SIZE-1:0]     i_target,
   input  logic [FXP_SIZE-1:0]     i_gain_max,
   output logic [FXP_SIZE-1:0]     o_gain,
   output logic                    o_gain_valid,
   output logic [1:0]              o_state
);
   localparam int SW     = 2 * FXP_SIZE;
   localparam int HOLD_W = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);
   localparam int REL_W  = (RELEASE_DIV < 2) ? 1 : $clog2(RELEASE_DIV);

   localparam logic [FXP_SIZE-1:0] UNITY     = FXP_SIZE'(1) << BITS_PER_GAIN_FRAC;
   localparam logic [SW-1:0]       MAG_SAT   = {1'b0, {(SW-1){1'b1}}};
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
   localparam logic [REL_W-1:0]    REL_LAST  = REL_W'(RELEASE_DIV - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ATTACK  = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [SW-1:0]       neg_sample;
   logic [SW-1:0]       abs_sample;
   logic [SW-1:0]       mag;
   logic                v1;

   logic [1:0]          state, state_nx;
   logic [FXP_SIZE-1:0] gain, gain_nx;
   logic [HOLD_W-1:0]   hold_cnt, hold_nx;
   logic [REL_W-1:0]    rel_cnt, rel_nx;
   logic                gain_valid;

   logic [FXP_SIZE-1:0] eff_max;
   logic [FXP_SIZE-1:0] atk_gain;
   logic [FXP_SIZE-1:0] up_gain;
   logic                overshoot;

   // Only the most-negative input still has its MSB set after negation.
   assign neg_sample = -i_sample;

   always_comb begin
      abs_sample = i_sample;
      if (i_sample[SW-1]) begin
         abs_sample = neg_sample[SW-1] ? MAG_SAT : neg_sample;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mag <= '0;
         v1  <= 1'b0;
      end else begin
         v1 <= i_valid;
         if (i_valid) begin
            mag <= abs_sample;
         end
      end
   end

   assign eff_max   = (i_gain_max > UNITY) ? i_gain_max : UNITY;
   assign overshoot = mag > {{FXP_SIZE{1'b0}}, i_target};
   assign up_gain   = (gain < eff_max) ? gain + FXP_SIZE'(1) : eff_max;

`ifdef AGC_FAST_ATTACK_EN
   assign atk_gain = ((gain >> 1) > UNITY) ? (gain >> 1) : UNITY;
`else
   assign atk_gain = (gain > UNITY) ? gain - FXP_SIZE'(1) : UNITY;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         gain       <= UNITY;
         hold_cnt   <= '0;
         rel_cnt    <= '0;
         gain_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         gain       <= gain_nx;
         hold_cnt   <= hold_nx;
         rel_cnt    <= rel_nx;
         gain_valid <= (gain_nx != gain);
      end
   end

   // Enable edges act immediately; all envelope-driven moves wait for a stage-2 sample.
   always_comb begin
      state_nx = state;
      gain_nx  = gain;
      hold_nx  = hold_cnt;
      rel_nx   = rel_cnt;
      if (state == S_IDLE) begin
         gain_nx = UNITY;
         if (i_enable) begin
            state_nx = S_RELEASE;
            rel_nx   = '0;
         end
      end else if (!i_enable) begin
         state_nx = S_IDLE;
         gain_nx  = UNITY;
         hold_nx  = '0;
         rel_nx   = '0;
      end else if (v1) begin
         if (overshoot) begin
            gain_nx  = (atk_gain < eff_max) ? atk_gain : eff_max;
            hold_nx  = HOLD_LOAD;
            state_nx = S_ATTACK;
         end else begin
            case (state)
               S_ATTACK: state_nx = S_HOLD;
               S_HOLD: begin
                  if (hold_cnt <= HOLD_W'(1)) begin
                     state_nx = S_RELEASE;
                     hold_nx  = '0;
                     rel_nx   = '0;
                  end else begin
                     hold_nx = hold_cnt - HOLD_W'(1);
                  end
               end
               default: begin
                  if (rel_cnt == REL_LAST) begin
                     rel_nx  = '0;
                     gain_nx = up_gain;
                  end else begin
                     rel_nx = rel_cnt + REL_W'(1);
                  end
               end
            endcase
            if (gain > eff_max) begin
               gain_nx = eff_max;
            end
         end
      end
   end

   always_comb begin
      o_gain       = gain;
      o_gain_valid = gain_valid;
      o_state      = state;
   end

endmodule
`default_nettype wire

// File: tb/tb_ovrd_auto_gain.sv
`default_nettype none
// tb_ovrd_auto_gain: directed and randomized checks of ovrd_auto_gain against a sample-level model.
module tb_ovrd_auto_gain;
   localparam int H     = 4;
   localparam int D     = 2;
   localparam int UNITY = 16;
`ifdef AGC_FAST_ATTACK_EN
   localparam int ATK1 = 16;
`else
   localparam int ATK1 = 31;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] sample;
   logic        enable;
   logic [15:0] target;
   logic [15:0] gain_max;
   logic [15:0] o_gain;
   logic        o_gain_valid;
   logic [1:0]  o_state;

   always #5 clk = ~clk;

   ovrd_auto_gain #(
      .FXP_SIZE(16), .BITS_PER_GAIN_FRAC(4), .HOLD_SAMPLES(H), .RELEASE_DIV(D)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(valid), .i_sample(sample), .i_enable(enable),
      .i_target(target), .i_gain_max(gain_max),
      .o_gain(o_gain), .o_gain_valid(o_gain_valid), .o_state(o_state)
   );

   int checks = 0;
   int errors = 0;

   // Reference: state as number, gain as integer, pending sample one cycle behind.
   int     m_state = 0;
   int     m_gain  = UNITY;
   int     m_hold  = 0;
   int     m_rel   = 0;
   bit     m_pulse = 1'b0;
   bit     p_valid = 1'b0;
   longint p_mag   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint abs_sat(input logic [31:0] s);
      longint v;
      v = longint'($signed(s));
      if (v < 0) v = -v;
      if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
      return v;
   endfunction

   task automatic model_edge();
      int old;
      int eff;
      int ng;
      old = m_gain;
      eff = (int'(gain_max) > UNITY) ? int'(gain_max) : UNITY;
      if (!rst) begin
         m_state = 0; m_gain = UNITY; m_hold = 0; m_rel = 0;
         p_valid = 1'b0; p_mag = 0;
      end else begin
         if (m_state == 0) begin
            m_gain = UNITY;
            if (enable) begin m_state = 3; m_rel = 0; end
         end else if (!enable) begin
            m_state = 0; m_gain = UNITY; m_hold = 0; m_rel = 0;
         end else if (p_valid) begin
            if (p_mag > longint'(target)) begin
`ifdef AGC_FAST_ATTACK_EN
               ng = m_gain / 2;
`else
               ng = m_gain - 1;
`endif
               if (ng < UNITY) ng = UNITY;
               if (ng > eff) ng = eff;
               m_gain = ng; m_hold = H; m_state = 1;
            end else begin
               ng = m_gain;
               if (m_state == 1) m_state = 2;
               else if (m_state == 2) begin
                  m_hold--;
                  if (m_hold <= 0) begin m_hold = 0; m_rel = 0; m_state = 3; end
               end else begin
                  m_rel++;
                  if (m_rel == D) begin
                     m_rel = 0;
                     ng = (m_gain + 1 > eff) ? eff : m_gain + 1;
                  end
               end
               if (m_gain > eff) ng = eff;
               m_gain = ng;
            end
         end
         p_valid = valid;
         if (valid) p_mag = abs_sat(sample);
      end
      m_pulse = (m_gain != old);
   endtask

   task automatic step(input bit v, input logic [31:0] s);
      valid  = v;
      sample = s;
      @(posedge clk);
      model_edge();
      #1;
      chk("model_gain",  32'(o_gain),       32'(m_gain));
      chk("model_state", 32'(o_state),      32'(m_state));
      chk("model_pulse", 32'(o_gain_valid), 32'(m_pulse));
   endtask

   initial begin
      logic [31:0] s;
      rst = 1'b0; valid = 1'b1; sample = 32'h7FFF_FFFF;
      enable = 1'b0; target = 16'h1000; gain_max = 16'h0020;

      // Reset with a live full-scale strobe
      step(1'b1, 32'h7FFF_FFFF);
      step(1'b1, 32'h7FFF_FFFF);
      chk("reset_gain",  32'(o_gain),       32'h10);
      chk("reset_state", 32'(o_state),      32'h0);
      chk("reset_pulse", 32'(o_gain_valid), 32'h0);
      rst = 1'b1;

      // Release ramp to the ceiling, then no further pulses
      enable = 1'b1;
      repeat (45) step(1'b1, 32'h0000_0100);
      chk("ramp_top_gain",  32'(o_gain),  32'h20);
      chk("ramp_top_state", 32'(o_state), 32'h3);
      repeat (6) begin
         step(1'b1, 32'h0000_0100);
         chk("ramp_no_pulse", 32'(o_gain_valid), 32'h0);
      end

      // Attack then hold then release
      step(1'b1, 32'h0002_0000);
      step(1'b1, 32'h0000_0100);
      chk("attack_gain",  32'(o_gain),  32'(ATK1));
      chk("attack_state", 32'(o_state), 32'h1);
      step(1'b1, 32'h0000_0100);
      chk("hold_state", 32'(o_state), 32'h2);
      repeat (3) step(1'b1, 32'h0000_0100);
      chk("hold_late_state", 32'(o_state), 32'h2);
      step(1'b1, 32'h0000_0100);
      chk("hold_to_release", 32'(o_state), 32'h3);

      // Most-negative sample saturates above the largest target
      target = 16'hFFFF;
      step(1'b1, 32'h8000_0000);
      step(1'b0, 32'h0);
      chk("sat_abs_state", 32'(o_state), 32'h1);
      target = 16'h1000;

      // Park at 0x18 in RELEASE, then drop enable as an overshoot reaches stage 2
      gain_max = 16'h0018;
      repeat (30) step(1'b1, 32'h0000_0100);
      chk("park_gain",  32'(o_gain),  32'h18);
      chk("park_state", 32'(o_state), 32'h3);
      step(1'b1, 32'h0002_0000);
      enable = 1'b0;
      step(1'b0, 32'h0);
      chk("endrop_gain",  32'(o_gain),       32'h10);
      chk("endrop_state", 32'(o_state),      32'h0);
      chk("endrop_pulse", 32'(o_gain_valid), 32'h1);
      step(1'b0, 32'h0);
      chk("endrop_single_pulse", 32'(o_gain_valid), 32'h0);

      // Ceiling lowered below unity clamps to unity
      enable = 1'b1; gain_max = 16'h0020;
      repeat (40) step(1'b1, 32'h0000_0100);
      chk("ceil_pre_gain", 32'(o_gain), 32'h20);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      gain_max = 16'h0008;
      step(1'b1, 32'h0000_0100);
      chk("ceil_wait_gain", 32'(o_gain), 32'h20);
      step(1'b0, 32'h0);
      chk("ceil_gain",  32'(o_gain),       32'h10);
      chk("ceil_pulse", 32'(o_gain_valid), 32'h1);

      // Randomized traffic against the model
      gain_max = 16'h0020;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) == 0) enable = ~enable;
         if ($urandom_range(49) == 0) begin
            case ($urandom_range(3))
               0: gain_max = 16'h0008;
               1: gain_max = 16'h0014;
               2: gain_max = 16'h0020;
               default: gain_max = 16'h0030;
            endcase
         end
         if ($urandom_range(29) == 0) begin
            case ($urandom_range(3))
               0: target = 16'h0000;
               1: target = 16'h0100;
               2: target = 16'hFFFF;
               default: target = 16'($urandom_range(16'hFFFF));
            endcase
         end
         rst = ($urandom_range(399) != 0);
         case ($urandom_range(5))
            0: s = 32'($urandom_range(255));
            1: s = 32'h8000_0000;
            2: s = -(32'(target) + 32'd1);
            3: s = $urandom();
            4: s = 32'(target);
            default: s = -32'(target);
         endcase
         step($urandom_range(9) < 7, s);
      end
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ovrd_auto_gain.md
Name: ovrd_auto_gain

Overview:
- Automatic gain controller that closes the loop around the overdrive stage.
- Consumes the double-width clamped sample stream from overdrive (o_sample/o_valid) and produces the gain word fed to overdrive's i_gain.
- Envelope-driven FSM:
  - fast gain reduction when output exceeds target;
  - hold period;
  - slow stepped release up to a programmable ceiling.
- Sits between the overdrive output and the effect-chain control registers.

Parameters:
- fxp_size, 16, width of gain word; input sample is 2*fxp_size bits.
- bits_per_gain_frac, 4, fractional bits of gain; unity = 1<<bits_per_gain_frac (16).
- hold_samples, 256, valid samples to hold gain after last overshoot.
- release_div, 64, valid samples per +1 LSB gain step during release.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  sample strobe (overdrive o_valid).
- i_sample  in  2*fxp_size  signed two's-complement sample (overdrive o_sample).
- i_enable  in  1  AGC enable; low forces unity gain.
- i_target  in  fxp_size  unsigned magnitude threshold, zero-extended for compare.
- i_gain_max  in  fxp_size  unsigned gain ceiling, same format as o_gain.
- o_gain  out  fxp_size  unsigned gain to overdrive i_gain.
- o_gain_valid  out  1  one-cycle pulse whenever o_gain changes value.
- o_state  out  2  FSM state: IDLE=0, ATTACK=1, HOLD=2, RELEASE=3.

Behaviour:
- Reset (rst=0 at posedge): o_gain=unity, o_gain_valid=0, o_state=IDLE, hold and release counters=0, magnitude register=0, pipeline valid=0. Reset mid-operation discards any in-flight sample.
- Stage 1 (on i_valid):
  - mag <= |i_sample|, saturating: most-negative value maps to 2^(2*fxp_size-1)-1.
  - v1 <= i_valid.
- Stage 2 (when v1=1): FSM decision. Gain change is registered and visible on o_gain 2 cycles after the i_valid cycle. o_gain_valid asserts in that same cycle.
- Overshoot: mag > i_target (strict). Zero-extend i_target to 2*fxp_size bits before comparing.
- eff_max = max(i_gain_max, unity).
- IDLE:
  - o_gain held at unity.
  - i_enable=1 -> RELEASE, release counter cleared.
- Any non-IDLE state with i_enable=0 -> IDLE next cycle, o_gain=unity (pulse if changed), counters cleared. Enable drop overrides every other event.
- Overshoot in any non-IDLE state (priority over hold/release):
  - gain <= max(gain-1, unity);
  - hold counter <= hold_samples;
  - state -> ATTACK.
- ATTACK, no overshoot -> HOLD.
- HOLD, no overshoot: hold counter decrements per valid sample. At 0 -> RELEASE, release counter cleared.
- RELEASE, no overshoot:
  - release counter increments per valid sample.
  - On reaching release_div-1: counter wraps to 0 and gain <= min(gain+1, eff_max).
  - At eff_max: stay in RELEASE, no pulse.
- Ceiling lowered live: if gain > eff_max on any stage-2 valid, gain <= eff_max immediately. This takes priority over a release step and combines with the attack decrement by using the lower result.
- No sample (v1=0): state, counters and gain are all held.
- Gain arithmetic is unsigned and never wraps. Floor is unity; ceiling is eff_max.

Optional Feature:
- Macro: AGC_FAST_ATTACK_EN.
- Defined: the overshoot step is gain <= max(gain>>1, unity) (halving) instead of -1 LSB.
- Undefined: -1 LSB step as above.
- All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles while i_valid=1 and i_sample=0x7FFF_FFFF. Required: o_gain=0x0010, o_state=0, o_gain_valid=0.
- Release ramp: hold_samples=4, release_div=2, i_enable=1, i_target=0x1000, i_gain_max=0x0020, continuous samples 0x0000_0100. Required: o_gain steps 16->17 after 2 valid samples, +1 every 2 samples, stops at 0x0020 in RELEASE with no further pulses.
- Attack/hold: at gain 0x0020, send one sample 0x0002_0000, then small samples. Required:
  - o_gain=0x001F two cycles after the strobe; o_state=ATTACK, then HOLD.
  - RELEASE after 4 more valid samples.
  - With AGC_FAST_ATTACK_EN defined, o_gain=0x0010 instead.
- Saturating abs: send i_sample=0x8000_0000 with i_target=0xFFFF. Required: treated as overshoot, ATTACK entered.
- Enable drop: deassert i_enable mid-RELEASE at gain 0x0018 in the same cycle as an overshoot sample reaches stage 2. Required: IDLE, o_gain=0x0010 with one o_gain_valid pulse; enable wins over attack.
- Ceiling change: at gain 0x0020, write i_gain_max=0x0008 and send a sample. Required: o_gain=0x0010, since a ceiling below unity clamps to unity.
